cipher_digit_feeder: RTL
========================

# cipher_digit_feeder

Upstream stage of the 8-digit seven-segment display driver. It collects four decimal digits from the keypad and runs a per-position mod-10 Caesar cipher over them, one digit per cycle. It then continuously presents ciphertext and plaintext digits with a free-running 2-bit scan index. The display driver consumes `enword`/`enrw` (cipher digits, com1–com4) and `word`/`worw` (plain digits, com5–com8).

## Interface
- `SCAN_DIV`, 50000 — clock cycles per scan-index step; legal range ≥2; benches use 4.
- `KEY`, 16'h3719 — four BCD key digits; key digit i = `KEY[4i+3:4i]` (k0=9, k1=1, k2=7, k3=3); every nibble ≤9.
- `clock`  in  1  — system clock.
- `reset`  in  1  — asynchronous, active-high.
- `key_valid`  in  1  — one-cycle strobe qualifying `key_digit`.
- `key_digit`  in  4  — entered digit; values >9 are ignored.
- `key_clear`  in  1  — abort entry, zero all buffers.
- `mode`  in  1  — 0 encrypt, 1 decrypt; sampled on entry to CIPHER.
- `enword`  out  4  — processed digit at position `enrw`.
- `word`  out  4  — entered digit at position `worw`.
- `enrw`  out  2  — scan index for `enword`.
- `worw`  out  2  — scan index for `word`; always equal to `enrw`.
- `busy`  out  1  — high during CIPHER.
- `done`  out  1  — high during SHOW.

## Operation
- States: ENTRY, CIPHER, SHOW. Reset enters ENTRY.
- ENTRY:
  - Each accepted digit (`key_valid` with `key_digit`≤9) is written to `plain[cnt]`, and the 2-bit `cnt` increments.
  - The 4th accepted digit moves the FSM to CIPHER with `cnt`=0.
- CIPHER:
  - One position per cycle, i=0..3: `res[i]` = `(plain[i]+k_i) mod 10` for encrypt, `(plain[i]+10−k_i) mod 10` for decrypt.
  - The 5-bit intermediate is reduced by a single conditional subtract of 10. It never exceeds 19.
  - After i=3, the FSM goes to SHOW.
  - `key_valid` is ignored in this state.
- SHOW: results are held. A valid digit clears `plain`/`res` to 0, is stored as `plain[0]` with `cnt`=1, and the FSM goes to ENTRY.
- `key_clear`, in any state:
  - Zeroes `plain`, `res`, and `cnt`, and the FSM goes to ENTRY.
  - It has priority over a simultaneous `key_valid`.
  - In CIPHER it aborts processing without completing.
- Scan:
  - The prescaler counts 0..SCAN_DIV−1 and wraps. At terminal count the scan index increments mod 4 (00→01→10→11→00).
  - The scan runs in all states and is unaffected by `key_clear`.
- Outputs:
  - `enword`=`res[scan]` and `word`=`plain[scan]`. Both are registered, so they reflect buffer contents one cycle after a write.
  - Partially entered digits appear on `word` immediately; `enword` shows 0 until CIPHER writes.

## Timing
- Reset values:
  - All outputs 0, `plain`/`res` 0, `cnt` 0, prescaler 0, scan 0.
  - `busy`=0, `done`=0, state ENTRY.
- If the 4th digit is accepted at edge N:
  - `busy`=1 on cycles N+1..N+4.
  - `res[i]` is written at edge N+1+i.
  - `done`=1 from N+5.
- Digit throughput: one per cycle; back-to-back strobes are all accepted.
- Scan step: `enrw` changes exactly every `SCAN_DIV` cycles. The first change comes `SCAN_DIV` cycles after reset release.
- `enword`/`word` update in the same cycle as `enrw`/`worw` (same register stage).

## Structure
- Shared package `cipher_pkg`:
  - state enum (ENTRY=0, CIPHER=1, SHOW=2)
  - `DIGIT_W`=4, `NUM_DIGITS`=4
  - default key constant
- Sub-module `mod10_cipher_unit`, combinational: inputs `d[3:0]`, `k[3:0]`, `mode`; output the mod-10 result.
- Top level holds the FSM, digit buffers, prescaler, and scan register.

## Test plan
- Reset, then `SCAN_DIV`=4 with no input:
  - `enrw`/`worw` step 0,1,2,3,0 every 4 cycles.
  - `enword`=`word`=0, `busy`=`done`=0.
- Encrypt, entering 1,2,3,4 back-to-back:
  - `busy` is high for 4 cycles, then `done`.
  - Scan shows `word` 1,2,3,4 and `enword` 0,3,0,7.
- Decrypt (`mode`=1), entering 0,3,0,7: `enword` 1,2,3,4 and `word` 0,3,0,7.
- Enter 5, then 12 (ignored), then 6,7,8: the 12 is dropped, and `word` reads 5,6,7,8 with `enword` 4,7,4,1.
- `key_clear` on the 2nd CIPHER cycle after entering 9,9,9,9:
  - Next cycle: ENTRY, `busy`=0, `done`=0, all buffers 0.
  - Scan index continues uninterrupted.
- In SHOW, enter 3, and assert `key_clear` together with `key_valid`: `plain` stays all 0, and the FSM stays in ENTRY with `cnt`=0.

Source files
------------

// File: rtl/cipher_digit_feeder_pkg.sv
// Shared definitions for the keypad cipher front end of the seven-segment display driver.
package cipher_pkg;

  localparam int DIGIT_W    = 4;
  localparam int NUM_DIGITS = 4;

  localparam logic [DIGIT_W*NUM_DIGITS-1:0] DEFAULT_KEY = 16'h3719;

  typedef enum logic [1:0] {
    ENTRY  = 2'd0,
    CIPHER = 2'd1,
    SHOW   = 2'd2
  } state_e;

endpackage

// File: rtl/mod10_cipher_unit.sv
// Combinational mod-10 Caesar step for one BCD digit (encrypt adds k, decrypt adds 10-k).
module mod10_cipher_unit
  import cipher_pkg::*;
(
  input  logic [DIGIT_W-1:0] d,
  input  logic [DIGIT_W-1:0] k,
  input  logic               mode,
  output logic [DIGIT_W-1:0] q
);

  logic [DIGIT_W:0] addend;
  logic [DIGIT_W:0] sum;

  // Both operands are at most 9 / 10, so the sum stays below 20 and one subtract suffices.
  always_comb begin
    addend = mode ? (5'd10 - {1'b0, k}) : {1'b0, k};
    sum    = {1'b0, d} + addend;
    q      = (sum >= 5'd10) ? DIGIT_W'(sum - 5'd10) : sum[DIGIT_W-1:0];
  end

endmodule

// File: rtl/cipher_digit_feeder.sv
// Collects four keypad digits, ciphers them one per cycle and scans plain/cipher digits to the display.
module cipher_digit_feeder
  import cipher_pkg::*;
#(
  parameter int          SCAN_DIV = 50000,
  parameter logic [15:0] KEY      = DEFAULT_KEY
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       key_valid,
  input  logic [3:0] key_digit,
  input  logic       key_clear,
  input  logic       mode,
  output logic [3:0] enword,
  output logic [3:0] word,
  output logic [1:0] enrw,
  output logic [1:0] worw,
  output logic       busy,
  output logic       done
);

  localparam logic [1:0] S_ENTRY  = 2'(ENTRY);
  localparam logic [1:0] S_CIPHER = 2'(CIPHER);
  localparam logic [1:0] S_SHOW   = 2'(SHOW);
  localparam int         PRE_W    = $clog2(SCAN_DIV);

  logic [1:0]         state;
  logic [1:0]         cnt;
  logic               mode_q;
  logic [DIGIT_W-1:0] plain [NUM_DIGITS];
  logic [DIGIT_W-1:0] res   [NUM_DIGITS];
  logic [DIGIT_W-1:0] key_sel;
  logic [DIGIT_W-1:0] cipher_q;
  logic               digit_ok;
  logic [PRE_W-1:0]   pre;
  logic [1:0]         scan;
  logic [1:0]         scan_nxt;

  assign digit_ok = key_valid && (key_digit <= 4'd9);
  assign key_sel  = KEY[{cnt, 2'b00} +: DIGIT_W];

  mod10_cipher_unit u_unit (
    .d    (plain[cnt]),
    .k    (key_sel),
    .mode (mode_q),
    .q    (cipher_q)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state  <= S_ENTRY;
      cnt    <= 2'd0;
      mode_q <= 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        plain[i] <= '0;
        res[i]   <= '0;
      end
    end else if (key_clear) begin
      state <= S_ENTRY;
      cnt   <= 2'd0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        plain[i] <= '0;
        res[i]   <= '0;
      end
    end else begin
      case (state)
        S_ENTRY: begin
          if (digit_ok) begin
            plain[cnt] <= key_digit;
            cnt        <= cnt + 2'd1;
            if (cnt == 2'd3) begin
              state  <= S_CIPHER;
              mode_q <= mode;
            end
          end
        end
        S_CIPHER: begin
          res[cnt] <= cipher_q;
          cnt      <= cnt + 2'd1;
          if (cnt == 2'd3) state <= S_SHOW;
        end
        S_SHOW: begin
          // A new digit starts a fresh word, so stale results are wiped with it.
          if (digit_ok) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
              plain[i] <= '0;
              res[i]   <= '0;
            end
            plain[0] <= key_digit;
            cnt      <= 2'd1;
            state    <= S_ENTRY;
          end
        end
        default: state <= S_ENTRY;
      endcase
    end
  end

  assign scan_nxt = (pre == PRE_W'(SCAN_DIV - 1)) ? scan + 2'd1 : scan;

  // Output digits are fetched with the next scan index so they change together with enrw/worw.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pre    <= '0;
      scan   <= 2'd0;
      enword <= '0;
      word   <= '0;
    end else begin
      pre    <= (pre == PRE_W'(SCAN_DIV - 1)) ? '0 : pre + 1'b1;
      scan   <= scan_nxt;
      enword <= res[scan_nxt];
      word   <= plain[scan_nxt];
    end
  end

  assign enrw = scan;
  assign worw = scan;
  assign busy = (state == S_CIPHER);
  assign done = (state == S_SHOW);

endmodule
